// File: rtl/tlb_refill_ctrl_pkg.sv
// Shared types and constants for the TLB refill controller.
package tlb_refill_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_FILL  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

  localparam int PTE_V         = 31;
  localparam int PTE_RO        = 30;
  localparam int PTE_PPN_HI    = 19;
  localparam int PTE_PPN_LO    = 12;
  localparam int PAGE_OFFSET_W = 12;
  localparam int VPN_W         = 32 - PAGE_OFFSET_W;

  // PTE address: table base plus VPN scaled to a word index, wrapping at 32 bits.
  function automatic logic [31:0] pte_addr_f(input logic [31:0] ptbr,
                                             input logic [VPN_W-1:0] vpn);
    return ptbr + {10'b0, vpn, 2'b00};
  endfunction

endpackage

// File: rtl/tlb_refill_ctrl_if.sv
// Miss, memory and refill signals between the refill controller and its
// environment. The controller uses the slave modport.
interface tlb_refill_ctrl_if #(
  parameter int PTE_W = 32
);
  logic [31:0]      ptbr_i;
  logic             imiss_i;
  logic [31:0]      imiss_vaddr_i;
  logic             dmiss_i;
  logic [31:0]      dmiss_vaddr_i;
  logic             mem_req_o;
  logic [31:0]      mem_addr_o;
  logic             mem_ack_i;
  logic [PTE_W-1:0] mem_data_i;
  logic             itlb_we_o;
  logic             dtlb_we_o;
  logic [19:0]      fill_physical_o;
  logic [31:0]      fill_virtual_o;
  logic             fill_read_only_o;
  logic             idone_o;
  logic             ddone_o;
  logic             ifault_o;
  logic             dfault_o;
  logic             busy_o;

  modport slave (
    input  ptbr_i, imiss_i, imiss_vaddr_i, dmiss_i, dmiss_vaddr_i,
           mem_ack_i, mem_data_i,
    output mem_req_o, mem_addr_o, itlb_we_o, dtlb_we_o,
           fill_physical_o, fill_virtual_o, fill_read_only_o,
           idone_o, ddone_o, ifault_o, dfault_o, busy_o
  );

  modport master (
    output ptbr_i, imiss_i, imiss_vaddr_i, dmiss_i, dmiss_vaddr_i,
           mem_ack_i, mem_data_i,
    input  mem_req_o, mem_addr_o, itlb_we_o, dtlb_we_o,
           fill_physical_o, fill_virtual_o, fill_read_only_o,
           idone_o, ddone_o, ifault_o, dfault_o, busy_o
  );

endinterface

// File: rtl/tlb_refill_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is the I side, bit 1 the D side;
// i_last = 1 means the D side was served most recently.
module tlb_refill_ctrl_rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  // One-hot grant; on a tie the side not served last wins.
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/tlb_refill_ctrl.sv
// Refill controller shared by the I-TLB and D-TLB: arbitrates misses,
// reads one PTE per walk and either writes the TLB or reports a fault.
module tlb_refill_ctrl
  import tlb_refill_ctrl_pkg::*;
#(
  parameter int PTE_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rsn_i,
  tlb_refill_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Last WAIT cycle before the walk gives up; the counter reaches TIMEOUT on this edge.
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  side_t              r_side;
  side_t              r_rr_last;
  side_t              w_grant_side;
  logic [VPN_W-1:0]   r_vpn;
  logic [VPN_W-1:0]   w_vpn_sel;
  logic [31:0]        r_pte_addr;
  logic [CNT_W-1:0]   r_cnt;
  logic [19:0]        r_fill_phys;
  logic [31:0]        r_fill_virt;
  logic               r_fill_ro;
  logic [1:0]         w_grant;
  logic               w_grant_any;
  logic [PTE_W-1:0]   w_pte;
  logic               w_unused_bits;

  assign w_pte         = bus.mem_data_i;
  assign w_unused_bits = ^{w_pte[29:20], w_pte[11:0],
                           bus.imiss_vaddr_i[PAGE_OFFSET_W-1:0],
                           bus.dmiss_vaddr_i[PAGE_OFFSET_W-1:0]};

  tlb_refill_ctrl_rr_arb2 u_arb (
    .i_req   ({bus.dmiss_i, bus.imiss_i}),
    .i_last  (r_rr_last == SIDE_D),
    .o_grant (w_grant)
  );

  assign w_grant_any  = |w_grant;
  assign w_grant_side = w_grant[1] ? SIDE_D : SIDE_I;
  assign w_vpn_sel    = w_grant[1] ? bus.dmiss_vaddr_i[31:PAGE_OFFSET_W]
                                   : bus.imiss_vaddr_i[31:PAGE_OFFSET_W];

  // Fill buses are registered and only change on a valid PTE, so they hold between fills.
  assign bus.fill_physical_o  = r_fill_phys;
  assign bus.fill_virtual_o   = r_fill_virt;
  assign bus.fill_read_only_o = r_fill_ro;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rsn_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and state-derived strobes.
  always_comb begin
    w_state_nxt   = r_state;
    bus.mem_req_o = 1'b0;
    bus.mem_addr_o = '0;
    bus.itlb_we_o = 1'b0;
    bus.dtlb_we_o = 1'b0;
    bus.idone_o   = 1'b0;
    bus.ddone_o   = 1'b0;
    bus.ifault_o  = 1'b0;
    bus.dfault_o  = 1'b0;
    bus.busy_o    = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_grant_any) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = r_pte_addr;
        w_state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        // An ack on the final counted cycle still wins over the timeout.
        if (bus.mem_ack_i)
          w_state_nxt = w_pte[PTE_V] ? S_FILL : S_FAULT;
        else if (r_cnt == LP_CNT_LAST)
          w_state_nxt = S_FAULT;
      end
      S_FILL: begin
        bus.itlb_we_o = (r_side == SIDE_I);
        bus.idone_o   = (r_side == SIDE_I);
        bus.dtlb_we_o = (r_side == SIDE_D);
        bus.ddone_o   = (r_side == SIDE_D);
        w_state_nxt   = S_IDLE;
      end
      S_FAULT: begin
        bus.ifault_o = (r_side == SIDE_I);
        bus.dfault_o = (r_side == SIDE_D);
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Walk context, timeout counter, arbitration history and fill registers.
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      r_side      <= SIDE_I;
      r_rr_last   <= SIDE_D;
      r_vpn       <= '0;
      r_pte_addr  <= '0;
      r_cnt       <= '0;
      r_fill_phys <= '0;
      r_fill_virt <= '0;
      r_fill_ro   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_side     <= w_grant_side;
            r_vpn      <= w_vpn_sel;
            r_pte_addr <= pte_addr_f(bus.ptbr_i, w_vpn_sel);
          end
        end
        S_REQ: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (bus.mem_ack_i && w_pte[PTE_V]) begin
            r_fill_phys <= {w_pte[PTE_PPN_HI:PTE_PPN_LO], {PAGE_OFFSET_W{1'b0}}};
            r_fill_virt <= {r_vpn, {PAGE_OFFSET_W{1'b0}}};
            r_fill_ro   <= w_pte[PTE_RO];
          end
        end
        S_FILL, S_FAULT: r_rr_last <= r_side;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Self-checking bench for tlb_refill_ctrl: reset state, round-robin ties,
// a vector table of walks, reset mid-walk, and randomized walks checked
// against a rule-level model.
module tb_tlb_refill_ctrl;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rsn = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  // Model state: last served side (1 = D) and the held fill bus values.
  logic        m_rr_last = 1'b1;
  logic [19:0] m_phys    = '0;
  logic [31:0] m_virt    = '0;
  logic        m_ro      = 1'b0;

  always #5 clk = ~clk;

  tlb_refill_ctrl_if #(.PTE_W(32)) bus ();

  tlb_refill_ctrl #(.PTE_W(32), .TIMEOUT(TMO)) dut (
    .clk_i (clk),
    .rsn_i (rsn),
    .bus   (bus)
  );

  typedef struct {
    logic        di;
    logic        dd;
    logic [31:0] ptbr;
    logic [31:0] iva;
    logic [31:0] dva;
    logic [31:0] pte;
    int          k;
    logic [31:0] e_addr;
    logic [5:0]  e_st;
    logic [19:0] e_phys;
    logic [31:0] e_virt;
    logic        e_ro;
    int          e_wait;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] strb();
    return {bus.itlb_we_o, bus.idone_o, bus.ifault_o,
            bus.dtlb_we_o, bus.ddone_o, bus.dfault_o};
  endfunction

  function automatic logic [5:0] exp_st_f(input logic side, input logic fault);
    if (!side) return fault ? 6'b001000 : 6'b110000;
    return fault ? 6'b000001 : 6'b000110;
  endfunction

  function automatic vec_t mk(input logic di, input logic dd, input logic [31:0] ptbr,
                              input logic [31:0] iva, input logic [31:0] dva,
                              input logic [31:0] pte, input int k,
                              input logic [31:0] e_addr, input logic [5:0] e_st,
                              input logic [19:0] e_phys, input logic [31:0] e_virt,
                              input logic e_ro, input int e_wait);
    vec_t v;
    v.di = di; v.dd = dd; v.ptbr = ptbr; v.iva = iva; v.dva = dva; v.pte = pte;
    v.k = k; v.e_addr = e_addr; v.e_st = e_st; v.e_phys = e_phys;
    v.e_virt = e_virt; v.e_ro = e_ro; v.e_wait = e_wait;
    return v;
  endfunction

  task automatic do_reset();
    rsn = 1'b1;
    repeat (2) @(negedge clk);
    rsn = 1'b0;
    m_rr_last = 1'b1; m_phys = '0; m_virt = '0; m_ro = 1'b0;
  endtask

  // Memory responder for one walk: waits for the request, acks on WAIT cycle k
  // (k = 0 never acks), returns at the negedge where a completion strobe shows.
  task automatic mem_walk(input logic [31:0] pte, input int k, output logic [31:0] addr,
                          output logic [5:0] st, output int req_lat, output int wait_lat);
    logic extra;
    extra = 1'b0; req_lat = 0; wait_lat = 0; addr = '0; st = '0;
    do begin
      @(negedge clk);
      req_lat++;
    end while (!bus.mem_req_o && req_lat < 10);
    if (!bus.mem_req_o) return;
    addr = bus.mem_addr_o;
    do begin
      @(negedge clk);
      wait_lat++;
      st = strb();
      if (st == 6'b0) begin
        if (bus.mem_req_o) extra = 1'b1;
        if (wait_lat == k) begin
          bus.mem_ack_i = 1'b1; bus.mem_data_i = pte;
        end else begin
          bus.mem_ack_i = 1'b0; bus.mem_data_i = $urandom;
        end
      end
    end while (st == 6'b0 && wait_lat < 20);
    chk("mem_req_single_cycle", 32'(extra), 32'd0);
  endtask

  task automatic run_one(input string nm, input logic di, input logic dd,
                         input logic [31:0] ptbr, input logic [31:0] iva,
                         input logic [31:0] dva, input logic [31:0] pte, input int k,
                         input logic [31:0] e_addr, input logic [5:0] e_st,
                         input logic [19:0] e_phys, input logic [31:0] e_virt,
                         input logic e_ro, input int e_wait);
    logic [31:0] addr;
    logic [5:0]  st;
    int          rl, wl;
    bus.ptbr_i = ptbr; bus.imiss_vaddr_i = iva; bus.dmiss_vaddr_i = dva;
    bus.imiss_i = di; bus.dmiss_i = dd;
    mem_walk(pte, k, addr, st, rl, wl);
    bus.imiss_i = 1'b0; bus.dmiss_i = 1'b0;
    bus.mem_ack_i = 1'b1; bus.mem_data_i = 32'h8000_0000 | $urandom;
    chk({nm, "_grant_lat"}, rl, 32'd1);
    chk({nm, "_mem_addr"}, addr, e_addr);
    chk({nm, "_strobes"}, 32'(st), 32'(e_st));
    chk({nm, "_wait_lat"}, wl, e_wait);
    chk({nm, "_busy_end"}, 32'(bus.busy_o), 32'd1);
    chk({nm, "_fill_phys"}, 32'(bus.fill_physical_o), 32'(e_phys));
    chk({nm, "_fill_virt"}, bus.fill_virtual_o, e_virt);
    chk({nm, "_fill_ro"}, 32'(bus.fill_read_only_o), 32'(e_ro));
    if (e_st[5] || e_st[2]) begin
      m_phys = e_phys; m_virt = e_virt; m_ro = e_ro;
    end
    m_rr_last = |e_st[2:0];
    @(negedge clk);
    chk({nm, "_busy_after"}, 32'(bus.busy_o), 32'd0);
    chk({nm, "_stray_ack_1"}, 32'(strb()), 32'd0);
    chk({nm, "_fill_hold"}, 32'(bus.fill_physical_o), 32'(e_phys));
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    chk({nm, "_stray_ack_2"}, 32'(strb()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] addr;
    logic [5:0]  st;
    int          rl, wl, n;
    logic        di, dd, side, got_ack, fault;
    logic [31:0] ptbr, iva, dva, pte, va;
    int          k;

    bus.ptbr_i = '0; bus.imiss_i = 1'b0; bus.imiss_vaddr_i = '0;
    bus.dmiss_i = 1'b0; bus.dmiss_vaddr_i = '0;
    bus.mem_ack_i = 1'b0; bus.mem_data_i = '0;

    do_reset();

    // Reset state
    chk("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
    chk("rst_strobes", 32'(strb()), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_fill_phys", 32'(bus.fill_physical_o), 32'd0);
    chk("rst_fill_virt", bus.fill_virtual_o, 32'd0);
    chk("rst_fill_ro", 32'(bus.fill_read_only_o), 32'd0);

    // Both misses held: I first after reset, then strict alternation.
    bus.ptbr_i = 32'h4000; bus.imiss_vaddr_i = 32'h0000_A000; bus.dmiss_vaddr_i = 32'h0000_B000;
    bus.imiss_i = 1'b1; bus.dmiss_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_walk(32'h8000_0000 | (32'(i + 1) << 12), 1, addr, st, rl, wl);
      bus.mem_ack_i = 1'b0;
      chk($sformatf("tie%0d_grant_lat", i), rl, (i == 0) ? 32'd1 : 32'd2);
      chk($sformatf("tie%0d_mem_addr", i), addr, (i % 2 == 0) ? 32'h4028 : 32'h402C);
      chk($sformatf("tie%0d_strobes", i), 32'(st), 32'(exp_st_f(1'(i % 2), 1'b0)));
      chk($sformatf("tie%0d_fill_phys", i), 32'(bus.fill_physical_o), 32'(i + 1) << 12);
    end
    bus.imiss_i = 1'b0; bus.dmiss_i = 1'b0;
    m_rr_last = 1'b1; m_phys = 20'h04000; m_virt = 32'h0000_B000; m_ro = 1'b0;
    @(negedge clk);
    chk("tie_busy_after", 32'(bus.busy_o), 32'd0);

    // Vector table
    vecs[0] = mk(1, 0, 32'h1000, 32'h0000_3ABC, 32'h0, 32'h8000_5000, 2,
                 32'h100C, 6'b110000, 20'h05000, 32'h0000_3000, 0, 3);
    vecs[1] = mk(0, 1, 32'h2000, 32'h0, 32'h1234_5678, 32'h4000_7000, 1,
                 32'h0004_AD14, 6'b000001, 20'h05000, 32'h0000_3000, 0, 2);
    vecs[2] = mk(0, 1, 32'h0, 32'h0, 32'hFFFF_F000, 32'h8000_1000, 0,
                 32'h003F_FFFC, 6'b000001, 20'h05000, 32'h0000_3000, 0, 5);
    vecs[3] = mk(1, 0, 32'h8000, 32'h0040_0123, 32'h0, 32'hC001_2000, 1,
                 32'h9000, 6'b110000, 20'h12000, 32'h0040_0000, 1, 2);
    vecs[4] = mk(0, 1, 32'hFFFF_FFF0, 32'h0, 32'h0000_5ABC, 32'h800A_BFFF, 4,
                 32'h0000_0004, 6'b000110, 20'hAB000, 32'h0000_5000, 0, 5);
    vecs[5] = mk(1, 0, 32'h100, 32'h0000_1FFF, 32'h0, 32'h8000_0000, 5,
                 32'h104, 6'b001000, 20'hAB000, 32'h0000_5000, 0, 5);
    for (int i = 0; i < 6; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].di, vecs[i].dd, vecs[i].ptbr, vecs[i].iva,
              vecs[i].dva, vecs[i].pte, vecs[i].k, vecs[i].e_addr, vecs[i].e_st,
              vecs[i].e_phys, vecs[i].e_virt, vecs[i].e_ro, vecs[i].e_wait);
    end

    // Reset during WAIT, then a late ack
    bus.ptbr_i = 32'h3000; bus.imiss_vaddr_i = '0; bus.dmiss_vaddr_i = 32'h0000_2000;
    bus.dmiss_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_req_o && n < 10);
    chk("rstw_req_seen", 32'(bus.mem_req_o), 32'd1);
    @(negedge clk);
    rsn = 1'b1;
    @(negedge clk);
    rsn = 1'b0; bus.dmiss_i = 1'b0;
    bus.mem_ack_i = 1'b1; bus.mem_data_i = 32'h8000_9000;
    m_rr_last = 1'b1; m_phys = '0; m_virt = '0; m_ro = 1'b0;
    chk("rstw_busy_0", 32'(bus.busy_o), 32'd0);
    chk("rstw_strobes_0", 32'(strb()), 32'd0);
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    chk("rstw_strobes_1", 32'(strb()), 32'd0);
    chk("rstw_busy_1", 32'(bus.busy_o), 32'd0);
    @(negedge clk);
    chk("rstw_strobes_2", 32'(strb()), 32'd0);
    chk("rstw_fill_phys", 32'(bus.fill_physical_o), 32'd0);
    chk("rstw_fill_virt", bus.fill_virtual_o, 32'd0);
    run_one("rstw_recover", 0, 1, 32'h3000, 32'h0, 32'h0000_2000, 32'h8000_9000, 1,
            32'h3008, 6'b000110, 20'h09000, 32'h0000_2000, 0, 2);

    // Randomized walks against the rule-level model
    for (int i = 0; i < 40; i++) begin
      di = 1'($urandom_range(0, 1));
      dd = 1'($urandom_range(0, 1));
      if (!di && !dd) di = 1'b1;
      ptbr = $urandom & ~32'h3;
      iva  = $urandom;
      dva  = $urandom;
      pte  = $urandom;
      k    = int'($urandom_range(0, 6));
      side = (di && dd) ? ~m_rr_last : dd;
      va   = side ? dva : iva;
      got_ack = (k >= 1 && k <= TMO);
      fault   = !got_ack || !pte[31];
      run_one($sformatf("rnd%0d", i), di, dd, ptbr, iva, dva, pte, k,
              ptbr + ((va >> 12) << 2), exp_st_f(side, fault),
              fault ? m_phys : {pte[19:12], 12'h000},
              fault ? m_virt : {va[31:12], 12'h000},
              fault ? m_ro : pte[30],
              got_ack ? k + 1 : TMO + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
